ff_sync_debounce: RTL and testbench
===================================

Name: ff_sync_debounce

Overview:
- Parametrised successor to the single-register input synchronizer.
- Each of WIDTH asynchronous inputs passes through a configurable N-stage synchronizer chain and a per-channel debounce filter, then an edge detector.
- Instantiated at the top level between the board buttons/switches/mouse-button lines and the game FSM, all in the pclk domain.
- Outputs a clean level plus one-cycle rise/fall pulses per channel.

Parameters:
- WIDTH, 1: number of independent channels.
- STAGES, 2: synchronizer flops per channel. Legal range is 2..4; an elaboration error is required outside this range.
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronized value must differ from the accepted level before it is accepted. The minimum is 1; 1 means no filtering beyond synchronization.
- RST_VAL, {WIDTH{1'b0}}: per-channel reset value for the synchronizer chain and the accepted level.

Ports:
- pclk  input  1  system pixel clock; all logic is on its rising edge.
- rst  input  1  reset, asynchronous and active-low; asserted when 0.
- din  input  WIDTH  raw asynchronous inputs.
- dout  output  WIDTH  debounced, synchronized level.
- rise  output  WIDTH  one-cycle pulse when dout[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when dout[i] goes 1->0.

Behaviour:
- Reset (rst=0, asynchronous)
  - Every synchronizer flop of channel i is set to RST_VAL[i].
  - dout is set to RST_VAL.
  - Per-channel counters are cleared to 0.
  - rise and fall are cleared to 0.
  - No pulse is generated on reset release, even if din differs from RST_VAL; the mismatch is filtered normally afterwards.
- Synchronizer
  - sync[0] <= din, then sync[k] <= sync[k-1].
  - s = sync[STAGES-1].
  - No logic is allowed between stages.
- Debounce counter
  - Width is $clog2(DEBOUNCE_CYCLES+1). Each channel is independent.
  - If s[i] == dout[i]: cnt[i] <= 0.
  - If s[i] != dout[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - If s[i] != dout[i] and cnt[i] == DEBOUNCE_CYCLES-1:
    - dout[i] <= s[i].
    - cnt[i] <= 0.
    - The matching rise[i] or fall[i] is set to 1 for exactly that one cycle, aligned with the dout change.
  - The counter never wraps or saturates past DEBOUNCE_CYCLES-1.
- Latency
  - Let din[i] change and then stay stable, with the change first sampled at edge E.
  - s changes after edge E+STAGES-1.
  - dout, rise and fall update after edge E+STAGES-1+DEBOUNCE_CYCLES.
- Glitch rejection
  - Any excursion of s shorter than DEBOUNCE_CYCLES consecutive cycles returns cnt to 0.
  - Such an excursion produces no dout change and no pulse.
- Simultaneous events
  - Channels change in the same cycle without interaction.
  - rise[i] and fall[i] are never both 1.
  - rise and fall are registered outputs, 0 in every cycle without an accepted change.
- Reset mid-operation: a partially counted transition is discarded and no pulse is emitted.

Test Plan (WIDTH=2, STAGES=2, DEBOUNCE_CYCLES=4, RST_VAL=2'b00):
- Reset behaviour
  - Stimulus: hold rst=0 with din=2'b11, then release rst.
  - Required: dout=00, rise=fall=00 while rst=0 and in the first cycle after release.
  - Required: dout=11 first 5 cycles after the first sampling edge (1 + 4), with rise=11 for one cycle and no fall.
- Latency
  - Stimulus: din[0] goes 0->1 just before edge E and stays high.
  - Required: dout[0]=1 and rise[0]=1 after edge E+5; rise[0]=0 from edge E+6 onward.
- Glitch rejection
  - Stimulus: din[1] high for exactly 3 cycles, then low.
  - Required: dout[1] stays 0 and rise[1] never pulses; internal cnt returns to 0.
- Fall path
  - Stimulus: with dout[0]=1, drive din[0]=0 for 10 cycles.
  - Required: dout[0]=0 five edges after the first low sample; fall[0]=1 for exactly one cycle; rise[0]=0 throughout.
- Independent channels
  - Stimulus: in the same cycle, din[0] goes 1->0 and din[1] goes 0->1, both held.
  - Required: fall[0]=1 and rise[1]=1 in the same cycle; dout goes 01->10.
- Asynchronous reset mid-count
  - Stimulus: din[0]=1 for 3 cycles, then rst=0 pulse between clock edges.
  - Required: dout=00 and cnt=0 immediately, without waiting for pclk; no rise pulse after release until din[0] has been held high for 4 filtered cycles again.

Source files
------------

// File: rtl/ff_sync_debounce.sv
// Multi-channel input conditioner: N-stage synchronizer, per-channel debounce
// filter and registered rise/fall pulse generation, all on pclk.
module ff_sync_debounce #(
  parameter int               WIDTH           = 1,
  parameter int               STAGES          = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL         = {WIDTH{1'b0}}
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("ff_sync_debounce: STAGES must be in the range 2..4");
  end

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("ff_sync_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] s;
  logic [CW-1:0]    cnt    [WIDTH];

  // Plain flop chain: nothing may sit between stages or metastability
  // settling time is lost.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RST_VAL;
      end
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[STAGES-1];

  // A channel accepts a new level only after DEBOUNCE_CYCLES consecutive
  // mismatching samples; any agreeing sample restarts the count.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      dout <= RST_VAL;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == dout[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LAST) begin
          dout[i] <= s[i];
          cnt[i]  <= '0;
          rise[i] <= s[i];
          fall[i] <= ~s[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ff_sync_debounce.sv
// Bench for ff_sync_debounce: directed checks with literal expectations plus a
// randomized run compared every cycle against a sample-window reference model.
module tb_ff_sync_debounce;

  localparam int         W   = 2;
  localparam int         ST  = 2;
  localparam int         D   = 4;
  localparam logic [W-1:0] RV = 2'b00;

  // clock / reset
  logic         pclk = 1'b0;
  logic         rst  = 1'b0;
  logic [W-1:0] din  = '0;
  logic [W-1:0] dout, rise, fall;

  always #5 pclk = ~pclk;

  ff_sync_debounce #(
    .WIDTH(W), .STAGES(ST), .DEBOUNCE_CYCLES(D), .RST_VAL(RV)
  ) dut (
    .pclk(pclk), .rst(rst), .din(din), .dout(dout), .rise(rise), .fall(fall)
  );

  int n_pass   = 0;
  int n_checks = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // reference model: s is din delayed by ST samples; a channel flips when the
  // last D samples of s all disagree with its current level
  logic [W-1:0] m_pipe[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_dout, exp_rise, exp_fall;

  task automatic model_reset();
    m_pipe.delete();
    for (int k = 0; k < ST; k++) m_pipe.push_back(RV);
    exp_q.delete();
    exp_dout = RV;
    exp_rise = '0;
    exp_fall = '0;
  endtask

  always @(negedge rst) model_reset();

  always @(posedge pclk) begin
    if (!rst) begin
      model_reset();
    end else begin
      logic [W-1:0] s_now;
      s_now = m_pipe[ST-1];
      exp_q.push_back(s_now);
      if (exp_q.size() > D) void'(exp_q.pop_front());
      exp_rise = '0;
      exp_fall = '0;
      if (exp_q.size() == D) begin
        for (int i = 0; i < W; i++) begin
          bit all_diff;
          all_diff = 1'b1;
          foreach (exp_q[j]) if (exp_q[j][i] == exp_dout[i]) all_diff = 1'b0;
          if (all_diff) begin
            exp_dout[i] = ~exp_dout[i];
            if (exp_dout[i]) exp_rise[i] = 1'b1;
            else             exp_fall[i] = 1'b1;
          end
        end
      end
      m_pipe.push_front(din);
      void'(m_pipe.pop_back());
    end
  end

  // per-cycle compare
  always @(negedge pclk) begin
    if (checking) begin
      chk("model_dout", dout, exp_dout);
      chk("model_rise", rise, exp_rise);
      chk("model_fall", fall, exp_fall);
      chk("rise_fall_excl", rise & fall, '0);
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic mid_reset_pulse();
    @(posedge pclk);
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    @(negedge pclk);
  endtask

  initial begin
    model_reset();
    // reset behaviour
    rst = 1'b0;
    din = 2'b11;
    cycles(3);
    checking = 1'b1;
    chk("rst_dout", dout, 2'b00);
    chk("rst_pulses", {rise, fall}, 4'b0000);
    chk("rst_cnt0", dut.cnt[0], 0);
    rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge pclk);
      if (k <= 5) chk("rel_dout_low", dout, 2'b00);
      if (k == 6) begin
        chk("rel_dout_high", dout, 2'b11);
        chk("rel_rise", rise, 2'b11);
      end
      if (k == 7) chk("rel_rise_clear", rise, 2'b00);
      chk("rel_no_fall", fall, 2'b00);
    end

    // latency on channel 0
    din = 2'b00;
    cycles(10);
    chk("lat_pre_dout", dout, 2'b00);
    din = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      @(negedge pclk);
      if (k == 5) chk("lat_dout_e4", dout[0], 1'b0);
      if (k == 6) begin
        chk("lat_dout_e5", dout[0], 1'b1);
        chk("lat_rise_e5", rise[0], 1'b1);
      end
      if (k == 7) chk("lat_rise_e6", rise[0], 1'b0);
    end

    // glitch rejection on channel 1
    din = 2'b11;
    cycles(3);
    din = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      @(negedge pclk);
      if (dout[1] !== 1'b0 || rise[1] !== 1'b0) chk("glitch_quiet", {dout[1], rise[1]}, 2'b00);
    end
    chk("glitch_dout", dout, 2'b01);
    chk("glitch_cnt1", dut.cnt[1], 0);

    // fall path on channel 0
    din = 2'b00;
    for (int k = 1; k <= 10; k++) begin
      @(negedge pclk);
      if (k == 5) chk("fall_dout_e4", dout[0], 1'b1);
      if (k == 6) begin
        chk("fall_dout_e5", dout[0], 1'b0);
        chk("fall_pulse", fall[0], 1'b1);
      end
      if (k == 7) chk("fall_clear", fall[0], 1'b0);
      if (rise[0] !== 1'b0) chk("fall_no_rise", rise[0], 1'b0);
    end

    // independent channels
    din = 2'b01;
    cycles(10);
    chk("ind_pre", dout, 2'b01);
    din = 2'b10;
    for (int k = 1; k <= 6; k++) begin
      @(negedge pclk);
      if (k == 5) chk("ind_dout_e4", dout, 2'b01);
      if (k == 6) begin
        chk("ind_dout_e5", dout, 2'b10);
        chk("ind_fall", fall, 2'b01);
        chk("ind_rise", rise, 2'b10);
      end
    end

    // asynchronous reset mid-count
    din = 2'b00;
    cycles(10);
    din = 2'b01;
    cycles(3);
    chk("arst_cnt_pre", dut.cnt[0], 1);
    @(posedge pclk);
    #2 rst = 1'b0;
    #1;
    chk("arst_dout", dout, 2'b00);
    chk("arst_cnt", dut.cnt[0], 0);
    #1 rst = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge pclk);
      if (k <= 6) chk("arst_no_rise", {rise[0], dout[0]}, 2'b00);
      if (k == 7) chk("arst_rise_again", rise[0], 1'b1);
    end

    // randomized run with occasional mid-cycle resets
    repeat (400) begin
      din = W'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) mid_reset_pulse();
      cycles($urandom_range(1, 8));
    end

    cycles(2);
    checking = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
